// File: rtl/dcpu_bus_arb.sv
// dcpu_bus_arb: two-master round-robin memory bus arbiter with burst limit.
// Ports: i_clk, i_reset (sync, active-high); master 0/1 bundles
//   i_mX_cs/we/addr/dat, o_mX_dat/ack; slave bundle o_s_cs/we/addr/dat,
//   i_s_dat/ack; o_owner (00 none, 01 m0, 10 m1); o_err timeout pulse.
// Optional slave watchdog: define DCPU_ARB_TIMEOUT_EN (limit = TIMEOUT).
module dcpu_bus_arb #(
  parameter int W        = 16,
  parameter int MAXBURST = 8,
  parameter int TIMEOUT  = 255
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_m0_cs,
  input  logic         i_m0_we,
  input  logic [W-1:0] i_m0_addr,
  input  logic [W-1:0] i_m0_dat,
  output logic [W-1:0] o_m0_dat,
  output logic         o_m0_ack,
  input  logic         i_m1_cs,
  input  logic         i_m1_we,
  input  logic [W-1:0] i_m1_addr,
  input  logic [W-1:0] i_m1_dat,
  output logic [W-1:0] o_m1_dat,
  output logic         o_m1_ack,
  output logic         o_s_cs,
  output logic         o_s_we,
  output logic [W-1:0] o_s_addr,
  output logic [W-1:0] o_s_dat,
  input  logic [W-1:0] i_s_dat,
  input  logic         i_s_ack,
  output logic [1:0]   o_owner,
  output logic         o_err
);

  localparam int BC = $clog2(MAXBURST + 1);
  localparam int BW = (BC > 4) ? BC : 4;
  localparam logic [BW-1:0] BMAX = BW'(MAXBURST);
  localparam logic [BW-1:0] BLIM = BW'(MAXBURST - 1);

  if (MAXBURST < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("dcpu_bus_arb: MAXBURST and TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t        state;
  logic          last;
  logic [BW-1:0] bcnt;

  logic          own0;
  logic          own1;
  logic          own;
  logic          m_cs;
  logic          m_we;
  logic          oth_cs;
  logic [W-1:0]  m_addr;
  logic [W-1:0]  m_dat;
  logic          ack;
  logic          to;
  logic          r_ack;
  logic [W-1:0]  r_dat;
  logic          burst_hit;
  logic          rel;

  assign own0 = (state == OWN0);
  assign own1 = (state == OWN1);
  assign own  = own0 | own1;

  always_comb begin
    m_cs   = 1'b0;
    m_we   = 1'b0;
    m_addr = '0;
    m_dat  = '0;
    oth_cs = 1'b0;
    unique case (1'b1)
      own0: begin
        m_cs   = i_m0_cs;
        m_we   = i_m0_we;
        m_addr = i_m0_addr;
        m_dat  = i_m0_dat;
        oth_cs = i_m1_cs;
      end
      own1: begin
        m_cs   = i_m1_cs;
        m_we   = i_m1_we;
        m_addr = i_m1_addr;
        m_dat  = i_m1_dat;
        oth_cs = i_m0_cs;
      end
      default: ;
    endcase
  end

  assign o_s_cs   = m_cs;
  assign o_s_we   = m_cs & m_we;
  assign o_s_addr = m_addr;
  assign o_s_dat  = m_dat;

  assign ack   = own & i_s_ack;
  assign r_ack = ack | to;
  assign r_dat = to ? '1 : i_s_dat;

  assign o_m0_ack = own0 & r_ack;
  assign o_m0_dat = own0 ? r_dat : '0;
  assign o_m1_ack = own1 & r_ack;
  assign o_m1_dat = own1 ? r_dat : '0;

  // Counter is still one short of the limit here: this ack is the last.
  assign burst_hit = ack & oth_cs & (bcnt >= BLIM);
  assign rel       = own & (~m_cs | burst_hit | to);

  assign o_owner = state;

`ifdef DCPU_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

  logic [TW-1:0] tcnt;

  // Fires on the TIMEOUT-th unacked cycle; a real ack wins.
  assign to    = own & m_cs & ~i_s_ack & (tcnt == TLIM);
  assign o_err = to;

  always_ff @(posedge i_clk) begin
    if (i_reset || !own || ack || rel) begin
      tcnt <= '0;
    end else if (m_cs) begin
      tcnt <= tcnt + 1'b1;
    end
  end
`else
  assign to    = 1'b0;
  assign o_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      last  <= 1'b1;
      bcnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          bcnt <= '0;
          if (i_m0_cs && (!i_m1_cs || last)) begin
            state <= OWN0;
            last  <= 1'b0;
          end else if (i_m1_cs) begin
            state <= OWN1;
            last  <= 1'b1;
          end
        end
        OWN0, OWN1: begin
          if (ack && bcnt != BMAX) bcnt <= bcnt + 1'b1;
          if (rel) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcpu_bus_arb.sv
// tb_dcpu_bus_arb: directed test-plan scenarios plus random traffic,
// checked every cycle against a behavioural arbiter model.
module tb_dcpu_bus_arb;

  localparam int MAXB = 8;
  localparam int TMO  = 16;
`ifdef DCPU_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        mcs[2];
  logic        mwe[2];
  logic [15:0] maddr[2];
  logic [15:0] mdat[2];
  logic        s_ack;
  logic [15:0] s_dat;

  logic [15:0] m0_dat, m1_dat, sa, sd;
  logic        m0_ack, m1_ack, scs, swe, err;
  logic [1:0]  owner;

  dcpu_bus_arb #(.W(16), .MAXBURST(MAXB), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_m0_cs(mcs[0]), .i_m0_we(mwe[0]),
    .i_m0_addr(maddr[0]), .i_m0_dat(mdat[0]),
    .o_m0_dat(m0_dat), .o_m0_ack(m0_ack),
    .i_m1_cs(mcs[1]), .i_m1_we(mwe[1]),
    .i_m1_addr(maddr[1]), .i_m1_dat(mdat[1]),
    .o_m1_dat(m1_dat), .o_m1_ack(m1_ack),
    .o_s_cs(scs), .o_s_we(swe),
    .o_s_addr(sa), .o_s_dat(sd),
    .i_s_dat(s_dat), .i_s_ack(s_ack),
    .o_owner(owner), .o_err(err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: owner 0 none / 1 m0 / 2 m1, prev = last granted master index.
  int own = 0;
  int prev = 1;
  int burst = 0;
  int waitc = 0;

  logic        c_scs, c_swe, c_err;
  logic [15:0] c_saddr, c_sdat;
  logic [1:0]  c_owner;
  logic        c_ack[2];
  logic [15:0] c_dat[2];
  logic        x_ack[2];
  bit          busy[2];

  task automatic chk(input string nm, input logic [15:0] a,
                     input logic [15:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic step();
    logic        e_scs, e_swe, e_err, to;
    logic [15:0] e_addr, e_sdat;
    logic        e_ack[2];
    logic [15:0] e_dat[2];
    int          x;
    bit          done;
    @(negedge clk);
    e_scs = 0; e_swe = 0; e_err = 0; to = 0;
    e_addr = 0; e_sdat = 0;
    e_ack[0] = 0; e_ack[1] = 0;
    e_dat[0] = 0; e_dat[1] = 0;
    if (own != 0) begin
      x = own - 1;
      e_scs  = mcs[x];
      e_swe  = mcs[x] & mwe[x];
      e_addr = maddr[x];
      e_sdat = mdat[x];
      to = TO_EN && mcs[x] && !s_ack && waitc == TMO - 1;
      e_ack[x] = s_ack | to;
      e_dat[x] = to ? 16'hFFFF : s_dat;
      e_err = to;
    end
    chk("s_cs", scs, e_scs);
    chk("s_we", swe, e_swe);
    chk("s_addr", sa, e_addr);
    chk("s_dat", sd, e_sdat);
    chk("m0_ack", m0_ack, e_ack[0]);
    chk("m0_dat", m0_dat, e_dat[0]);
    chk("m1_ack", m1_ack, e_ack[1]);
    chk("m1_dat", m1_dat, e_dat[1]);
    chk("owner", owner, 16'(own));
    chk("err", err, e_err);
    c_scs = scs; c_swe = swe; c_err = err;
    c_saddr = sa; c_sdat = sd; c_owner = owner;
    c_ack[0] = m0_ack; c_ack[1] = m1_ack;
    c_dat[0] = m0_dat; c_dat[1] = m1_dat;
    x_ack[0] = e_ack[0]; x_ack[1] = e_ack[1];
    if (rst) begin
      own = 0; prev = 1; burst = 0; waitc = 0;
    end else if (own == 0) begin
      if (mcs[0] && mcs[1]) x = 1 - prev;
      else if (mcs[0]) x = 0;
      else if (mcs[1]) x = 1;
      else x = -1;
      if (x >= 0) begin
        own = x + 1; prev = x; burst = 0; waitc = 0;
      end
    end else begin
      x = own - 1;
      done = !mcs[x] || to ||
             (s_ack && mcs[1-x] && burst + 1 >= MAXB);
      if (s_ack && burst < MAXB) burst++;
      if (s_ack || done) waitc = 0;
      else if (mcs[x]) waitc++;
      if (done) own = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int i = 0; i < 2; i++) begin
      mcs[i] = 0; mwe[i] = 0; maddr[i] = 0; mdat[i] = 0;
    end
    s_ack = 0; s_dat = 0;
  endtask

  initial begin
    clr();
    rst = 1;
    @(posedge clk); #1;
    step();
    rst = 0;
    chk("rst_owner", c_owner, 2'b00);
    chk("rst_scs", c_scs, 0);
    chk("rst_ack0", c_ack[0], 0);

    // single master read, ack on cycle 3
    mcs[0] = 1; maddr[0] = 16'h0040;
    step();
    chk("a_idle_scs", c_scs, 0);
    step();
    chk("a_owner", c_owner, 2'b01);
    chk("a_scs", c_scs, 1);
    chk("a_addr", c_saddr, 16'h0040);
    step();
    s_ack = 1; s_dat = 16'hBEEF;
    step();
    chk("a_ack", c_ack[0], 1);
    chk("a_dat", c_dat[0], 16'hBEEF);
    chk("a_ack1", c_ack[1], 0);
    mcs[0] = 0; s_ack = 0;
    step(); step();
    chk("a_end", c_owner, 2'b00);

    // tie after reset
    rst = 1; step(); rst = 0;
    mcs[0] = 1; mcs[1] = 1;
    step(); step();
    chk("b_first", c_owner, 2'b01);
    mcs[0] = 0;
    step(); step();
    chk("b_idle", c_owner, 2'b00);
    step();
    chk("b_second", c_owner, 2'b10);
    mcs[1] = 0;
    step(); step();

    // burst limit
    mcs[0] = 1; mcs[1] = 1; s_ack = 1; s_dat = 16'h00A5;
    step();
    for (int i = 0; i < MAXB; i++) begin
      step();
      chk("c_m0_own", c_owner, 2'b01);
      chk("c_m0_ack", c_ack[0], 1);
    end
    step();
    chk("c_gap", c_owner, 2'b00);
    step();
    chk("c_m1_own", c_owner, 2'b10);
    chk("c_m1_ack", c_ack[1], 1);
    step();
    mcs[1] = 0; s_ack = 0;
    step(); step();
    chk("c_gap2", c_owner, 2'b00);
    step();
    chk("c_regrant", c_owner, 2'b01);
    mcs[0] = 0;
    step(); step();

    // write masking
    mcs[1] = 1; mwe[1] = 1;
    maddr[1] = 16'h0100; mdat[1] = 16'h1234;
    step();
    chk("d_idle_we", c_swe, 0);
    s_ack = 1; s_dat = 16'h5555;
    step();
    chk("d_owner", c_owner, 2'b10);
    chk("d_we", c_swe, 1);
    chk("d_sdat", c_sdat, 16'h1234);
    chk("d_m0_ack", c_ack[0], 0);
    chk("d_m0_dat", c_dat[0], 16'h0000);
    mcs[1] = 0; s_ack = 0;
    step();
    chk("d_mask_we", c_swe, 0);
    step();
    clr();

    // reset mid-transfer
    mcs[0] = 1;
    step(); step();
    rst = 1;
    step();
    rst = 0; s_ack = 1;
    step();
    chk("e_owner", c_owner, 2'b00);
    chk("e_scs", c_scs, 0);
    chk("e_ack", c_ack[0], 0);
    clr();
    step(); step(); step();

`ifdef DCPU_ARB_TIMEOUT_EN
    mcs[1] = 1;
    step();
    for (int i = 1; i <= TMO; i++) begin
      step();
      if (i == TMO - 1) chk("w_early", c_ack[1], 0);
      if (i == TMO) begin
        chk("w_ack", c_ack[1], 1);
        chk("w_dat", c_dat[1], 16'hFFFF);
        chk("w_err", c_err, 1);
      end
    end
    mcs[1] = 0;
    step();
    chk("w_idle", c_owner, 2'b00);
    step();
`endif

    // random traffic
    clr();
    busy[0] = 0; busy[1] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int x = 0; x < 2; x++) begin
        if (busy[x] && x_ack[x]) busy[x] = 0;
        if (!busy[x] && $urandom_range(3) == 0) begin
          busy[x] = 1;
          mwe[x] = 1'($urandom);
          maddr[x] = 16'($urandom);
          mdat[x] = 16'($urandom);
        end
        mcs[x] = busy[x];
      end
      s_ack = ($urandom_range(2) == 0);
      s_dat = 16'($urandom);
      rst = ($urandom_range(499) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dcpu_bus_arb.md
# dcpu_bus_arb

Two-master, one-slave memory bus arbiter that lets the dcpu core share its single memory port with a second master: the debug/loader or DMA engine. It sits between the masters and the memory/peripheral fabric. Ownership is granted round-robin, and a burst limit bounds how long one master can hold the bus. An optional watchdog terminates transfers the slave never acknowledges.

## Interface
Parameters:
- W, 16, data and address width
- MAXBURST, 8, acknowledged transfers one master may complete while the other waits
- TIMEOUT, 255, watchdog limit in cycles (only with DCPU_ARB_TIMEOUT_EN)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, synchronous, active-high
- i_m0_cs, i_m0_we  in  1  master 0 (CPU) request and write enable
- i_m0_addr, i_m0_dat  in  W  master 0 address and write data
- o_m0_dat  out  W  master 0 read data
- o_m0_ack  out  1  master 0 acknowledge
- i_m1_cs, i_m1_we, i_m1_addr, i_m1_dat, o_m1_dat, o_m1_ack  same widths as master 0  master 1 (debug/DMA) equivalents
- o_s_cs, o_s_we  out  1  slave select and write enable
- o_s_addr, o_s_dat  out  W  slave address and write data
- i_s_dat  in  W  slave read data
- i_s_ack  in  1  slave acknowledge
- o_owner  out  2  00 none, 01 master 0, 10 master 1
- o_err  out  1  one-cycle timeout pulse

## Operation
- State machine: IDLE, OWN0, OWN1.
- A master requests by holding its cs high. The request, we, addr and dat must stay stable until that master sees ack.
- IDLE, neither cs high: stay in IDLE.
- IDLE, exactly one cs high: go to OWN of that master.
- IDLE, both cs high: grant the master that is not `last`, where `last` is the previous owner.
- On entry to OWNx: `last` becomes x and the burst counter clears.
- In OWNx, the slave bus is a straight copy of master x: o_s_cs = i_mx_cs, plus we, addr and dat.
- o_mx_ack = i_s_ack and o_mx_dat = i_s_dat for the owner.
- The non-owner always sees ack 0 and dat 0.
- Each cycle with i_s_ack high in OWNx increments the burst counter. The counter is 4 bits minimum and saturates at MAXBURST.
- Release OWNx to IDLE in either case:
  - i_mx_cs is low.
  - i_s_ack is high, the other master's cs is high, and the counter reaches MAXBURST on this ack.
- Release takes effect on the next clock edge. The slave sees no cs during the IDLE cycle that follows.
- In IDLE, all slave outputs are 0 and all master acks are 0.
- Writes are masked by cs: o_s_we is 0 whenever o_s_cs is 0.

## Timing
- Reset state:
  - IDLE, with `last` = master 1, so master 0 wins the first tie.
  - Burst and timeout counters 0.
  - o_s_cs, o_s_we, o_s_addr, o_s_dat = 0.
  - o_m0_ack, o_m1_ack, o_m0_dat, o_m1_dat = 0.
  - o_owner = 00, o_err = 0.
- Grant latency is one cycle. A cs rising in IDLE produces o_s_cs on the next cycle.
- An owner that keeps cs high is not re-arbitrated; its transfers run back-to-back.
- Ack and read data are combinational passthrough: i_s_ack and i_s_dat reach the owner in the same cycle.
- On a forced release, the waiting master owns the bus two cycles after the releasing ack: one IDLE cycle, then OWN.
- A cs that drops in the same cycle as ack ends the transfer normally.
- Reset asserted mid-transfer forces IDLE on the next edge. The in-flight transfer is abandoned with no ack.
- o_owner is registered and matches the state.

## Configuration
- DCPU_ARB_TIMEOUT_EN defined:
  - A counter runs while in OWNx with o_s_cs high and i_s_ack low. It clears on ack and on state change.
  - When the counter reaches TIMEOUT, the arbiter drives o_mx_ack = 1 and o_mx_dat = all-ones for one cycle, pulses o_err, and releases to IDLE.
  - A slave ack arriving in that same cycle takes priority: normal ack, no o_err.
- DCPU_ARB_TIMEOUT_EN undefined:
  - No watchdog; a transfer waits indefinitely.
  - o_err is tied to 0 and the TIMEOUT parameter is unused.

## Test plan
- Single master: m0 reads 0x0040 and the slave acks on cycle 3 with 0xBEEF. Required: o_s_cs one cycle after cs, o_m0_dat = 0xBEEF with o_m0_ack, o_m1_ack never set.
- Tie after reset: m0 and m1 raise cs in the same cycle. Required: m0 granted first (o_owner = 01); when m0 drops cs, one IDLE cycle, then o_owner = 10.
- Burst limit: m0 holds cs for 20 single-cycle-ack transfers while m1 waits, MAXBURST = 8. Required: release after m0's 8th ack, m1 granted two cycles later, m0 regranted when m1 drops cs.
- Write masking: m1 writes 0x1234 to 0x0100 while m0 has cs low. Required: o_s_we = 1 and o_s_dat = 0x1234 only while o_owner = 10; m0 sees ack 0 and dat 0 throughout.
- Reset mid-transfer: i_reset asserted while in OWN0 with ack pending. Required: next cycle IDLE, o_s_cs = 0, o_owner = 00, no ack.
- Watchdog (DCPU_ARB_TIMEOUT_EN, TIMEOUT = 16): slave never acks m1. Required: on cycle 16, o_m1_ack = 1, o_m1_dat = 0xFFFF, o_err pulse, then IDLE.
